// File: rtl/req_encoder_seq_if.sv
// Handshake bundle for req_encoder_seq: request capture on one side, one encoded index per accept on the other.
interface req_encoder_seq_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
);
  logic [WIDTH-1:0] iReq;
  logic             iLoad;
  logic             iReady;
  logic [IDX_W-1:0] oIndex;
  logic             oValid;
  logic             oBusy;
  logic             oDone;
  logic [IDX_W:0]   oCount;

  modport master (
    output iReq, iLoad, iReady,
    input  oIndex, oValid, oBusy, oDone, oCount
  );

  modport slave (
    input  iReq, iLoad, iReady,
    output oIndex, oValid, oBusy, oDone, oCount
  );
endinterface

// File: rtl/req_encoder_seq.sv
// Sequential priority encoder: captures a request vector, then emits the index of every
// pending line, one per accepted handshake, and pulses oDone when the set is exhausted.
module req_encoder_seq #(
  parameter int WIDTH      = 32,
  parameter int IDX_W      = 5,
  parameter int ACTIVE_LOW = 1,
  parameter int HIGH_FIRST = 0
) (
  input logic               clk,
  input logic               rst,
  req_encoder_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W:0]   count_q, count_d;

  logic [WIDTH-1:0] load_pend;
  logic [WIDTH-1:0] remaining;

  function automatic logic [IDX_W-1:0] prio_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) if (v[i]) idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + (IDX_W+1)'(v[i]);
    return cnt;
  endfunction

  assign load_pend = (ACTIVE_LOW != 0) ? ~bus.iReq : bus.iReq;
  // The line currently presented is the one retired on accept.
  assign remaining = pend_q & ~(WIDTH'(1) << index_q);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    index_d = index_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iLoad) begin
          pend_d  = load_pend;
          count_d = popcount(load_pend);
          busy_d  = 1'b1;
          if (load_pend != '0) begin
            state_d = EMIT;
            valid_d = 1'b1;
            index_d = prio_idx(load_pend);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      EMIT: begin
        if (valid_q && bus.iReady) begin
          pend_d = remaining;
          if (remaining != '0) begin
            index_d = prio_idx(remaining);
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      index_q <= index_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign bus.oIndex = index_q;
  assign bus.oValid = valid_q;
  assign bus.oBusy  = busy_q;
  assign bus.oDone  = done_q;
  assign bus.oCount = count_q;

endmodule

// File: tb/tb_req_encoder_seq.sv
// Directed bench for req_encoder_seq: a low-first and a high-first instance share one stimulus stream.
module tb_req_encoder_seq;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  req_encoder_seq_if #(.WIDTH(32), .IDX_W(5)) if_lo ();
  req_encoder_seq_if #(.WIDTH(32), .IDX_W(5)) if_hi ();

  assign if_hi.iReq   = if_lo.iReq;
  assign if_hi.iLoad  = if_lo.iLoad;
  assign if_hi.iReady = if_lo.iReady;

  req_encoder_seq #(.WIDTH(32), .IDX_W(5), .ACTIVE_LOW(1), .HIGH_FIRST(0)) dut_lo (
    .clk (clk),
    .rst (rst),
    .bus (if_lo.slave)
  );

  req_encoder_seq #(.WIDTH(32), .IDX_W(5), .ACTIVE_LOW(1), .HIGH_FIRST(1)) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (if_hi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_emit(input string tag, input int idx, input int cnt);
    chk({tag, "_valid"}, 32'(if_lo.oValid), 32'd1);
    chk({tag, "_index"}, 32'(if_lo.oIndex), 32'(idx));
    chk({tag, "_count"}, 32'(if_lo.oCount), 32'(cnt));
    chk({tag, "_busy"},  32'(if_lo.oBusy),  32'd1);
    chk({tag, "_done"},  32'(if_lo.oDone),  32'd0);
  endtask

  task automatic chk_done(input string tag, input int cnt);
    chk({tag, "_valid"}, 32'(if_lo.oValid), 32'd0);
    chk({tag, "_done"},  32'(if_lo.oDone),  32'd1);
    chk({tag, "_busy"},  32'(if_lo.oBusy),  32'd1);
    chk({tag, "_count"}, 32'(if_lo.oCount), 32'(cnt));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(if_lo.oValid), 32'd0);
    chk({tag, "_done"},  32'(if_lo.oDone),  32'd0);
    chk({tag, "_busy"},  32'(if_lo.oBusy),  32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst          = 1'b1;
    if_lo.iReq   = 32'hFFFF_FFFF;
    if_lo.iLoad  = 1'b0;
    if_lo.iReady = 1'b0;

    // reset
    step();
    step();
    chk_idle("rst");
    chk("rst_index", 32'(if_lo.oIndex), 32'd0);
    chk("rst_count", 32'(if_lo.oCount), 32'd0);
    chk("rst_hi_valid", 32'(if_hi.oValid), 32'd0);
    rst = 1'b0;
    step();
    chk_idle("rst_rel");

    // single line
    if_lo.iReq = 32'hFFFF_FFFE; if_lo.iLoad = 1'b1; if_lo.iReady = 1'b1;
    step();
    if_lo.iLoad = 1'b0;
    chk_emit("single", 0, 1);
    step();
    chk_done("single_d", 1);
    step();
    chk_idle("single_i");

    // burst, both priority orders
    if_lo.iReq = 32'h7FFF_FF5F; if_lo.iLoad = 1'b1;
    step();
    if_lo.iLoad = 1'b0;
    chk_emit("burst0", 5, 3);
    chk("burst0_hi", 32'(if_hi.oIndex), 32'd31);
    step();
    chk_emit("burst1", 7, 3);
    chk("burst1_hi", 32'(if_hi.oIndex), 32'd7);
    step();
    chk_emit("burst2", 31, 3);
    chk("burst2_hi", 32'(if_hi.oIndex), 32'd5);
    step();
    chk_done("burst_d", 3);
    chk("burst_hi_done", 32'(if_hi.oDone), 32'd1);
    step();
    chk_idle("burst_i");

    // backpressure; iReq change after capture must not matter
    if_lo.iReq = 32'hFFFF_EFFB; if_lo.iLoad = 1'b1; if_lo.iReady = 1'b0;
    step();
    if_lo.iLoad = 1'b0;
    if_lo.iReq  = 32'h0000_0000;
    chk_emit("bp_load", 2, 2);
    chk("bp_hi", 32'(if_hi.oIndex), 32'd12);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_emit("bp_hold", 2, 2);
    end
    if_lo.iReady = 1'b1;
    step();
    chk_emit("bp_next", 12, 2);
    chk("bp_next_hi", 32'(if_hi.oIndex), 32'd2);
    step();
    chk_done("bp_d", 2);
    step();
    chk_idle("bp_i");

    // empty load
    if_lo.iReq = 32'hFFFF_FFFF; if_lo.iLoad = 1'b1;
    step();
    if_lo.iLoad = 1'b0;
    chk_done("empty_d", 0);
    step();
    chk_idle("empty_i");
    chk("empty_count", 32'(if_lo.oCount), 32'd0);

    // loads during EMIT and DONE are ignored; first accepted after DONE
    if_lo.iReq = 32'h7FFF_FF5F; if_lo.iLoad = 1'b1;
    step();
    if_lo.iReq = 32'hFFFF_FFFE;
    chk_emit("ign0", 5, 3);
    step();
    chk_emit("ign1", 7, 3);
    step();
    chk_emit("ign2", 31, 3);
    step();
    chk_done("ign_d", 3);
    step();
    chk_idle("ign_i");
    chk("ign_i_count", 32'(if_lo.oCount), 32'd3);
    step();
    if_lo.iLoad = 1'b0;
    chk_emit("reload", 0, 1);
    step();
    chk_done("reload_d", 1);
    step();
    chk_idle("reload_i");

    // reset mid-EMIT
    if_lo.iReq = 32'h7FFF_FF5F; if_lo.iLoad = 1'b1;
    step();
    if_lo.iLoad = 1'b0;
    chk_emit("mid0", 5, 3);
    step();
    chk_emit("mid1", 7, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("mid_rst");
    chk("mid_rst_index", 32'(if_lo.oIndex), 32'd0);
    chk("mid_rst_count", 32'(if_lo.oCount), 32'd0);
    step();
    chk_idle("mid_after");
    if_lo.iReq = 32'hFFFF_FFFE; if_lo.iLoad = 1'b1;
    step();
    if_lo.iLoad = 1'b0;
    chk_emit("fresh", 0, 1);
    step();
    chk_done("fresh_d", 1);
    step();
    chk_idle("fresh_i");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
